// File: rtl/puf_key_collector.sv
// puf_key_collector
// Counts rising edges of one ring-oscillator pair (A and B) inside a counting
// window. On every `done` pulse it resolves one key bit (A faster than B -> 1).
// After KEY_BITS bits it presents the key on a valid/ack handshake and holds
// it there until the consumer accepts it.
module puf_key_collector #(
    parameter int CNT_W       = 16,
    parameter int KEY_BITS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SEL_W       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ro_a,
    input  logic                ro_b,
    input  logic                enable_ro,
    input  logic                start_count,
    input  logic                done,
    output logic [SEL_W-1:0]    pair_sel,
    output logic [KEY_BITS-1:0] key_out,
    output logic                key_valid,
    input  logic                key_ack,
    output logic [SEL_W:0]      bit_cnt,
    output logic                tie_seen,
    output logic                sat_seen,
    output logic                drop_seen
);

    localparam int                BC_W     = SEL_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [SEL_W-1:0]  SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0]  SEL_ZERO = {SEL_W{1'b0}};
    localparam logic [BC_W-1:0]   BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0]   BC_ZERO  = {BC_W{1'b0}};
    localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(KEY_BITS - 1);
    localparam logic [KEY_BITS-1:0] KEY_ZERO = {KEY_BITS{1'b0}};

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
    logic                 prev_a_q, prev_a_d;
    logic                 prev_b_q, prev_b_d;
    logic                 start_prev_q, start_prev_d;
    logic [CNT_W-1:0]     cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]     cnt_b_q, cnt_b_d;
    logic [KEY_BITS-1:0]  shift_q, shift_d;
    logic [KEY_BITS-1:0]  key_out_q, key_out_d;
    logic                 key_valid_q, key_valid_d;
    logic [SEL_W-1:0]     pair_sel_q, pair_sel_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 tie_seen_q, tie_seen_d;
    logic                 sat_seen_q, sat_seen_d;
    logic                 drop_seen_q, drop_seen_d;

    logic                 rise_a_s;
    logic                 rise_b_s;
    logic                 start_rise_s;
    logic                 count_en_s;
    logic                 new_bit_s;

    // Next-state logic: synchronizers, edge counters, bit collection FSM and handshake.
    always_comb begin
        state_d      = state_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        shift_d      = shift_q;
        key_out_d    = key_out_q;
        key_valid_d  = key_valid_q;
        pair_sel_d   = pair_sel_q;
        bit_cnt_d    = bit_cnt_q;
        tie_seen_d   = tie_seen_q;
        sat_seen_d   = sat_seen_q;
        drop_seen_d  = drop_seen_q;

        // Synchronizer chains shift towards the MSB; the MSB is the usable value.
        sync_a_d     = {sync_a_q[SYNC_STAGES-2:0], ro_a};
        sync_b_d     = {sync_b_q[SYNC_STAGES-2:0], ro_b};
        prev_a_d     = sync_a_q[SYNC_STAGES-1];
        prev_b_d     = sync_b_q[SYNC_STAGES-1];
        start_prev_d = start_count;

        rise_a_s     = sync_a_q[SYNC_STAGES-1] & ~prev_a_q;
        rise_b_s     = sync_b_q[SYNC_STAGES-1] & ~prev_b_q;
        start_rise_s = start_count & ~start_prev_q;
        count_en_s   = enable_ro & start_count;
        new_bit_s    = (cnt_a_q > cnt_b_q) ? 1'b1 : 1'b0;

        // A new window clears both counters; edges in that cycle are discarded.
        if (start_rise_s) begin
            cnt_a_d = CNT_ZERO;
            cnt_b_d = CNT_ZERO;
        end else begin
            if (count_en_s && rise_a_s) begin
                if (cnt_a_q == CNT_MAX) begin
                    sat_seen_d = 1'b1;
                end else begin
                    cnt_a_d = cnt_a_q + CNT_ONE;
                end
            end else begin
                cnt_a_d = cnt_a_q;
            end
            if (count_en_s && rise_b_s) begin
                if (cnt_b_q == CNT_MAX) begin
                    sat_seen_d = 1'b1;
                end else begin
                    cnt_b_d = cnt_b_q + CNT_ONE;
                end
            end else begin
                cnt_b_d = cnt_b_q;
            end
        end

        // The comparison always uses the registered (pre-clear) counts.
        case (state_q)
            ST_COLLECT: begin
                if (done) begin
                    shift_d   = {shift_q[KEY_BITS-2:0], new_bit_s};
                    bit_cnt_d = bit_cnt_q + BC_ONE;
                    if (cnt_a_q == cnt_b_q) begin
                        tie_seen_d = 1'b1;
                    end else begin
                        tie_seen_d = tie_seen_q;
                    end
                    if (bit_cnt_q == BC_LAST) begin
                        key_out_d   = {shift_q[KEY_BITS-2:0], new_bit_s};
                        key_valid_d = 1'b1;
                        pair_sel_d  = SEL_ZERO;
                        state_d     = ST_HOLD;
                    end else begin
                        pair_sel_d  = pair_sel_q + SEL_ONE;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (done) begin
                    drop_seen_d = 1'b1;
                end else begin
                    drop_seen_d = drop_seen_q;
                end
                // The ack clear wins over any flag set in the same cycle.
                if (key_ack && key_valid_q) begin
                    key_valid_d = 1'b0;
                    bit_cnt_d   = BC_ZERO;
                    shift_d     = KEY_ZERO;
                    tie_seen_d  = 1'b0;
                    sat_seen_d  = 1'b0;
                    drop_seen_d = 1'b0;
                    state_d     = ST_COLLECT;
                end else begin
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_COLLECT;
            sync_a_q     <= {SYNC_STAGES{1'b0}};
            sync_b_q     <= {SYNC_STAGES{1'b0}};
            prev_a_q     <= 1'b0;
            prev_b_q     <= 1'b0;
            start_prev_q <= 1'b0;
            cnt_a_q      <= CNT_ZERO;
            cnt_b_q      <= CNT_ZERO;
            shift_q      <= KEY_ZERO;
            key_out_q    <= KEY_ZERO;
            key_valid_q  <= 1'b0;
            pair_sel_q   <= SEL_ZERO;
            bit_cnt_q    <= BC_ZERO;
            tie_seen_q   <= 1'b0;
            sat_seen_q   <= 1'b0;
            drop_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_a_q     <= sync_a_d;
            sync_b_q     <= sync_b_d;
            prev_a_q     <= prev_a_d;
            prev_b_q     <= prev_b_d;
            start_prev_q <= start_prev_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            shift_q      <= shift_d;
            key_out_q    <= key_out_d;
            key_valid_q  <= key_valid_d;
            pair_sel_q   <= pair_sel_d;
            bit_cnt_q    <= bit_cnt_d;
            tie_seen_q   <= tie_seen_d;
            sat_seen_q   <= sat_seen_d;
            drop_seen_q  <= drop_seen_d;
        end
    end

    assign pair_sel  = pair_sel_q;
    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign bit_cnt   = bit_cnt_q;
    assign tie_seen  = tie_seen_q;
    assign sat_seen  = sat_seen_q;
    assign drop_seen = drop_seen_q;

endmodule

// File: tb/tb_puf_key_collector.sv
// Directed bench for puf_key_collector: a default instance plus a CNT_W=4
// instance (sharing all inputs) used to observe counter saturation.
module tb_puf_key_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ro_a, ro_b, enable_ro, start_count, done, key_ack;

    logic [2:0] pair_sel,  pair_sel4;
    logic [7:0] key_out,   key_out4;
    logic       key_valid, key_valid4;
    logic [3:0] bit_cnt,   bit_cnt4;
    logic       tie_seen,  tie_seen4;
    logic       sat_seen,  sat_seen4;
    logic       drop_seen, drop_seen4;

    int n_checks = 0;
    int n_errors = 0;

    puf_key_collector dut (
        .clk(clk), .rst_n(rst_n), .ro_a(ro_a), .ro_b(ro_b),
        .enable_ro(enable_ro), .start_count(start_count), .done(done),
        .pair_sel(pair_sel), .key_out(key_out), .key_valid(key_valid),
        .key_ack(key_ack), .bit_cnt(bit_cnt), .tie_seen(tie_seen),
        .sat_seen(sat_seen), .drop_seen(drop_seen)
    );

    puf_key_collector #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ro_a(ro_a), .ro_b(ro_b),
        .enable_ro(enable_ro), .start_count(start_count), .done(done),
        .pair_sel(pair_sel4), .key_out(key_out4), .key_valid(key_valid4),
        .key_ack(key_ack), .bit_cnt(bit_cnt4), .tie_seen(tie_seen4),
        .sat_seen(sat_seen4), .drop_seen(drop_seen4)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Restart the counting window: one low cycle, then a rising start_count.
    task automatic open_window();
        @(negedge clk);
        start_count = 1'b0;
        @(negedge clk);
        start_count = 1'b1;
        enable_ro   = 1'b1;
    endtask

    // Produce na rising edges on ro_a and nb on ro_b, slow enough to synchronize.
    task automatic ro_edges(input int na, input int nb);
        int n;
        n = (na > nb) ? na : nb;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ro_a = (i < na);
            ro_b = (i < nb);
            repeat (2) @(negedge clk);
            ro_a = 1'b0;
            ro_b = 1'b0;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
    endtask

    // One-cycle done pulse; returns on the negedge after it was sampled.
    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic window(input int na, input int nb);
        open_window();
        ro_edges(na, nb);
        pulse_done();
    endtask

    initial begin
        rst_n = 1'b0; ro_a = 1'b0; ro_b = 1'b0; enable_ro = 1'b0;
        start_count = 1'b0; done = 1'b0; key_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        check_eq("rst_pair_sel",  pair_sel,  32'd0);
        check_eq("rst_key_out",   key_out,   32'd0);
        check_eq("rst_key_valid", key_valid, 32'd0);
        check_eq("rst_bit_cnt",   bit_cnt,   32'd0);
        check_eq("rst_flags",     {tie_seen, sat_seen, drop_seen}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_key_valid", key_valid, 32'd0);
        end

        // Single bit, a > b.
        window(40, 25);
        check_eq("bit1_bit_cnt",  bit_cnt,        32'd1);
        check_eq("bit1_pair_sel", pair_sel,       32'd1);
        check_eq("bit1_lsb",      dut.shift_q[0], 32'd1);
        check_eq("bit1_sat",      sat_seen,       32'd0);

        // Remaining seven bits alternate a < b, a > b ... -> 8'hAA.
        for (int k = 1; k < 8; k++) begin
            if (k == 7) check_eq("pre_last_pair_sel", pair_sel, 32'd7);
            if ((k % 2) == 1) window(5, 10);
            else              window(10, 5);
        end
        check_eq("key_valid", key_valid, 32'd1);
        check_eq("key_out",   key_out,   32'hAA);
        check_eq("key_pair_sel_wrap", pair_sel, 32'd0);
        check_eq("key_bit_cnt", bit_cnt, 32'd8);
        check_eq("key_tie",   tie_seen,  32'd0);

        // HOLD: done pulses are dropped.
        pulse_done();
        pulse_done();
        check_eq("hold_key_out",   key_out,   32'hAA);
        check_eq("hold_drop",      drop_seen, 32'd1);
        check_eq("hold_bit_cnt",   bit_cnt,   32'd8);
        check_eq("hold_key_valid", key_valid, 32'd1);

        // Acknowledge.
        @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check_eq("ack_key_valid", key_valid, 32'd0);
        check_eq("ack_flags",     {tie_seen, sat_seen, drop_seen}, 32'd0);
        check_eq("ack_bit_cnt",   bit_cnt,   32'd0);
        check_eq("ack_key_kept",  key_out,   32'hAA);
        check_eq("ack_pair_sel",  pair_sel,  32'd0);

        // Tie: 30 edges each gives 0 and raises tie_seen.
        window(30, 30);
        check_eq("tie_bit",     dut.shift_q[0], 32'd0);
        check_eq("tie_seen",    tie_seen,       32'd1);
        check_eq("tie_bit_cnt", bit_cnt,        32'd1);

        // Saturation on the 4-bit instance: 20 edges on A hold at 15.
        open_window();
        ro_edges(20, 0);
        check_eq("sat4_cnt_a",  dut4.cnt_a_q, 32'd15);
        check_eq("sat4_flag",   sat_seen4,    32'd1);
        check_eq("wide_cnt_a",  dut.cnt_a_q,  32'd20);
        check_eq("wide_no_sat", sat_seen,     32'd0);
        pulse_done();
        check_eq("sat_bit",     dut.shift_q[0], 32'd1);

        // done coincident with a start_count rise: old counts, then clear.
        open_window();
        ro_edges(12, 5);
        check_eq("pre_cnt_a", dut.cnt_a_q, 32'd12);
        check_eq("pre_cnt_b", dut.cnt_b_q, 32'd5);
        @(negedge clk);
        start_count = 1'b0;
        @(negedge clk);
        start_count = 1'b1;
        done        = 1'b1;
        @(negedge clk);
        done        = 1'b0;
        check_eq("coin_shift",   dut.shift_q[2:0], 32'd3);
        check_eq("coin_bit_cnt", bit_cnt,          32'd3);
        check_eq("coin_cnt_a",   dut.cnt_a_q,      32'd0);
        check_eq("coin_cnt_b",   dut.cnt_b_q,      32'd0);

        // Reset mid-key discards the three collected bits.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_count = 1'b0;
        enable_ro   = 1'b0;
        check_eq("mid_rst_bit_cnt",  bit_cnt,     32'd0);
        check_eq("mid_rst_pair_sel", pair_sel,    32'd0);
        check_eq("mid_rst_shift",    dut.shift_q, 32'd0);
        check_eq("mid_rst_tie",      tie_seen,    32'd0);
        repeat (5) @(negedge clk);
        check_eq("mid_rst_key_valid", key_valid,  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/puf_key_collector.md
Name: puf_key_collector

Overview:
- Measurement-side counterpart of the PUF control sequencer.
- Consumes `enable_ro`, `start_count` and the `done` pulse, and counts rising edges of one selected ring-oscillator pair.
- On each `done` pulse, resolves one key bit by count comparison and advances to the next RO pair.
- After KEY_BITS bits, presents the assembled key on a valid/ack handshake to the downstream key consumer.

Parameters:
- CNT_W, 16: width of each edge counter (saturating).
- KEY_BITS, 8: number of key bits assembled per key; must be ≥ 2.
- SYNC_STAGES, 2: synchronizer depth for the asynchronous RO inputs; must be ≥ 2.
- SEL_W, 3: width of `pair_sel`; must satisfy 2^SEL_W ≥ KEY_BITS.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `ro_a`, input, 1: selected RO pair output A, asynchronous to `clk`.
- `ro_b`, input, 1: selected RO pair output B, asynchronous to `clk`.
- `enable_ro`, input, 1: RO enable from the sequencer; gates counting.
- `start_count`, input, 1: counting window, level-high.
- `done`, input, 1: one-cycle measurement-complete pulse.
- `pair_sel`, output, SEL_W: index of the RO pair currently under measurement.
- `key_out`, output, KEY_BITS: assembled key; stable while `key_valid` is high.
- `key_valid`, output, 1: key available; level-held until acknowledged.
- `key_ack`, input, 1: consumer accepts the key.
- `bit_cnt`, output, SEL_W+1: number of bits collected into the current key.
- `tie_seen`, output, 1: sticky flag; some bit in the current key came from equal counts.
- `sat_seen`, output, 1: sticky flag; some counter saturated during the current key.
- `drop_seen`, output, 1: sticky flag; a `done` pulse arrived while in HOLD.

Behaviour:
- Reset, asynchronous on `rst_n` low:
  - State COLLECT.
  - Counters, shift register, `pair_sel`, `bit_cnt`, `key_out` = 0.
  - `key_valid`, `tie_seen`, `sat_seen`, `drop_seen` = 0.
  - Synchronizer and edge-detect flops = 0.
  - A reset mid-key discards all partial bits.
- Synchronization:
  - `ro_a` and `ro_b` each pass through SYNC_STAGES flops.
  - A rising edge is `sync == 1` while the previous synced value `== 0`.
  - Edges are counted only when `enable_ro` and `start_count` are both 1 in that cycle.
- Counter clear:
  - On a `start_count` rising edge (registered previous value 0, current 1), both counters load 0 in that cycle; edges in that same cycle are not counted.
  - Counting begins the following cycle.
  - Counters hold their values when `start_count` is low.
- Saturation: a counter at all-ones stays there, and `sat_seen` is set.
- State COLLECT, on `done == 1`:
  - bit = 1 if `cnt_a > cnt_b`, else 0. A tie gives 0 and sets `tie_seen`.
  - The shift register shifts left with bit as the new LSB, so the first bit collected ends up at MSB `key_out[KEY_BITS-1]`.
  - `bit_cnt` increments and `pair_sel` increments.
  - All updates are visible the cycle after `done`.
- Key completion:
  - If this `done` brings `bit_cnt` to KEY_BITS, then on the next cycle:
    - `key_out` = the full shift value;
    - `key_valid` = 1;
    - state = HOLD;
    - `pair_sel` wraps to 0.
  - `bit_cnt` reads KEY_BITS while in HOLD.
- State HOLD:
  - `done` pulses are ignored: no shift, no counter of record changes, and `drop_seen` is set.
  - Edge counting continues normally; it is harmless.
- Handshake:
  - `key_ack` is honoured only while `key_valid == 1`.
  - When honoured, the next cycle brings: `key_valid` = 0; `bit_cnt`, shift register, `tie_seen`, `sat_seen`, `drop_seen` cleared; state COLLECT.
  - `key_out` retains the last key until the next completion.
  - `key_ack` while `key_valid == 0` has no effect.
- Simultaneous events:
  - `done` in the same cycle as a `start_count` rising edge: the comparison uses the pre-clear counts, then the counters clear.
  - `key_ack` and `done` in the same HOLD cycle: `done` is dropped (`drop_seen` set, then cleared by the ack). The next `done` is collected as bit 0 of the new key.
- `pair_sel` values 0 .. KEY_BITS-1 only. It never exceeds KEY_BITS-1.
- No combinational paths from inputs to outputs; all outputs are registered.

Test Plan:
- Reset/idle: hold `rst_n` = 0 for 3 cycles, then release → all outputs 0 and `pair_sel` = 0; `key_valid` stays 0 over 20 idle cycles.
- Single bit:
  - Stimulus: `start_count` rise; `ro_a` toggles 40 edges and `ro_b` 25 edges in the window; then `done`.
  - Required: the cycle after `done`, `bit_cnt` = 1, `pair_sel` = 1, shift LSB = 1.
- Full key (KEY_BITS = 8):
  - Stimulus: eight windows with a > b, a < b alternating, starting with a > b.
  - Required: the cycle after the 8th `done`, `key_valid` = 1, `key_out` = 8'hAA, `pair_sel` = 0.
- Tie and saturation:
  - Stimulus: a window with equal counts of 30 edges each.
  - Required: bit 0 and `tie_seen` = 1.
  - Stimulus: with CNT_W = 4, drive 20 edges on A.
  - Required: `cnt_a` holds at 15 and `sat_seen` = 1.
- HOLD behaviour: while `key_valid` = 1, pulse `done` twice → `key_out` unchanged, `drop_seen` = 1, `bit_cnt` = 8.
  - Then assert `key_ack` → the next cycle brings `key_valid` = 0, flags 0, `bit_cnt` = 0.
- Corner cases:
  - `done` coincident with a `start_count` rise → the bit uses the old counts (a = 12, b = 5 gives 1), and the counters read 0 the next cycle.
  - `rst_n` pulsed low after 3 bits → `bit_cnt` = 0, no `key_valid`.
